// File: rtl/stepper_motor_ctrl_pkg.sv
// Shared definitions for the stepper controller: half-step coil table,
// step-index type and the direction/speed button encodings.
package stepper_pkg;

    localparam int IDX_W = 3;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {DIR_FWD = 1'b0, DIR_REV = 1'b1} dir_e;
    typedef enum logic {SPD_SLOW = 1'b0, SPD_FAST = 1'b1} spd_e;

    // {in1,in2,in3,in4} per index, element 0 is the rightmost entry
    localparam logic [7:0][3:0] HALF_STEP = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    function automatic logic [3:0] coil_pattern(idx_t idx);
        return HALF_STEP[idx];
    endfunction

endpackage

// File: rtl/stepper_motor_ctrl_if.sv
// Button inputs and coil/LED outputs of the stepper controller.
interface stepper_motor_ctrl_if;
    logic btn_start_stop;
    logic btn_direction_control;
    logic btn_speed;
    logic in1, in2, in3, in4;
    logic led, led1, led2, led3;

    modport master (
        output btn_start_stop, btn_direction_control, btn_speed,
        input  in1, in2, in3, in4, led, led1, led2, led3
    );

    modport slave (
        input  btn_start_stop, btn_direction_control, btn_speed,
        output in1, in2, in3, in4, led, led1, led2, led3
    );
endinterface

// File: rtl/stepper_motor_ctrl_btn_debounce.sv
// Two-flop synchronizer followed by a stability filter: dout follows the
// synchronized input only after DEB_CYCLES consecutive differing cycles.
module btn_debounce #(
    parameter int DEB_CYCLES = 270_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        // any return to the filtered level drops the partial count
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = filt_q;
endmodule

// File: rtl/stepper_motor_ctrl.sv
// Half-step unipolar stepper driver: debounced run/dir/speed buttons, a
// prescaled step tick, registered coil drive and status LEDs.
module stepper_motor_ctrl
    import stepper_pkg::*;
#(
    parameter int CLK_HZ     = 27_000_000,
    parameter int SLOW_DIV   = 54_000,
    parameter int FAST_DIV   = 27_000,
    parameter int DEB_CYCLES = 270_000
) (
    input  logic                 clk,
    input  logic                 rst,
    stepper_motor_ctrl_if.slave  bus
);
    localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int CNT_W   = $clog2(MAX_DIV);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

    logic run, dir, spd;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk(clk), .rst(rst), .din(bus.btn_start_stop), .dout(run));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .clk(clk), .rst(rst), .din(bus.btn_direction_control), .dout(dir));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_spd (
        .clk(clk), .rst(rst), .din(bus.btn_speed), .dout(spd));

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_last;
    logic             tick;
    idx_t             idx_q, idx_d;
    logic [3:0]       coil_q, coil_d;
    logic [3:0]       led_q, led_d;

    always_comb begin
        div_last = (spd == logic'(SPD_FAST)) ? FAST_LAST : SLOW_LAST;
        // >= rather than == so a slow->fast switch past the new limit ticks at once
        tick     = run && (cnt_q >= div_last);
        cnt_d    = (!run || tick) ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (dir == logic'(DIR_REV)) ? idx_q - 1'b1 : idx_q + 1'b1;
        end
        coil_d   = run ? coil_pattern(idx_q) : 4'b0000;
        led_d    = {run, dir, spd, led_q[0] ^ tick};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            coil_q <= 4'b0000;
            led_q  <= 4'b0000;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            coil_q <= coil_d;
            led_q  <= led_d;
        end
    end

    assign bus.in1  = coil_q[3];
    assign bus.in2  = coil_q[2];
    assign bus.in3  = coil_q[1];
    assign bus.in4  = coil_q[0];
    assign bus.led  = led_q[3];
    assign bus.led1 = led_q[2];
    assign bus.led2 = led_q[1];
    assign bus.led3 = led_q[0];
endmodule

// File: tb/tb_stepper_motor_ctrl.sv
// Directed bench for stepper_motor_ctrl with SLOW_DIV=8, FAST_DIV=4, DEB_CYCLES=3.
module tb_stepper_motor_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    stepper_motor_ctrl_if bus_if ();

    stepper_motor_ctrl #(
        .CLK_HZ(27_000_000), .SLOW_DIV(8), .FAST_DIV(4), .DEB_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus_if)
    );

    always #5 clk = ~clk;

    // index -> {in1,in2,in3,in4}, written out by hand
    logic [3:0] pat [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    function automatic logic [3:0] coils();
        return {bus_if.in1, bus_if.in2, bus_if.in3, bus_if.in4};
    endfunction

    function automatic logic [3:0] leds();
        return {bus_if.led, bus_if.led1, bus_if.led2, bus_if.led3};
    endfunction

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus_if.btn_start_stop        = 1'b0;
        bus_if.btn_direction_control = 1'b0;
        bus_if.btn_speed             = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("reset_coils", {4'b0, coils()}, 8'h00);
        chk("reset_leds",  {4'b0, leds()},  8'h00);
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            chk("idle", {coils(), leds()}, 8'h00);
        end

        // start slow forward; filtered run rises 5 edges later, LED/coils one after
        bus_if.btn_start_stop = 1'b1;
        cyc(5);
        chk("led_before_deb", {7'b0, bus_if.led}, 8'h00);
        cyc(1);
        chk("led_run", {7'b0, bus_if.led}, 8'h01);
        chk("first_coils", {4'b0, coils()}, {4'b0, pat[0]});
        chk("first_led3", {7'b0, bus_if.led3}, 8'h00);
        cyc(7);
        chk("hold_7cyc", {4'b0, coils()}, {4'b0, pat[0]});
        cyc(1);
        for (int k = 1; k <= 8; k++) begin
            chk("fwd_step", {4'b0, coils()}, {4'b0, pat[k % 8]});
            chk("fwd_led3", {7'b0, bus_if.led3}, 8'(k % 2));
            if (k < 8) cyc(8);
        end

        // reverse; next tick goes 0 -> 7
        bus_if.btn_direction_control = 1'b1;
        cyc(6);
        chk("led1_dir", {7'b0, bus_if.led1}, 8'h01);
        chk("pre_rev", {4'b0, coils()}, {4'b0, pat[0]});
        cyc(2);
        chk("rev_wrap", {4'b0, coils()}, {4'b0, pat[7]});
        cyc(8);
        chk("rev_6", {4'b0, coils()}, {4'b0, pat[6]});
        cyc(8);
        chk("rev_5", {4'b0, coils()}, {4'b0, pat[5]});

        // filtered speed lands with counter at 6 -> tick on the next cycle
        bus_if.btn_speed = 1'b1;
        cyc(6);
        chk("led2_spd", {7'b0, bus_if.led2}, 8'h01);
        chk("pre_fast", {4'b0, coils()}, {4'b0, pat[5]});
        cyc(1);
        chk("fast_immediate", {4'b0, coils()}, {4'b0, pat[4]});
        for (int k = 3; k >= -1; k--) begin
            cyc(4);
            chk("fast_step", {4'b0, coils()}, {4'b0, pat[(k + 8) % 8]});
        end

        // stop between the ticks that reach index 5 and index 4
        cyc(4);
        chk("at_idx6", {4'b0, coils()}, {4'b0, pat[6]});
        bus_if.btn_start_stop = 1'b0;
        cyc(6);
        chk("stop_coils", {4'b0, coils()}, 8'h00);
        chk("stop_leds", {4'b0, leds()}, 8'b0000_0111);

        // short pulse must be filtered out
        bus_if.btn_start_stop = 1'b1;
        cyc(2);
        bus_if.btn_start_stop = 1'b0;
        cyc(18);
        chk("pulse_coils", {4'b0, coils()}, 8'h00);
        chk("pulse_leds", {4'b0, leds()}, 8'b0000_0111);

        // restart resumes at index 5
        bus_if.btn_start_stop = 1'b1;
        cyc(6);
        chk("resume", {4'b0, coils()}, {4'b0, pat[5]});
        chk("resume_led", {7'b0, bus_if.led}, 8'h01);

        // reset mid-run with buttons still held
        cyc(3);
        rst = 1'b1;
        cyc(1);
        chk("rst_mid", {coils(), leds()}, 8'h00);
        rst = 1'b0;
        cyc(5);
        chk("reacq_wait", {coils(), leds()}, 8'h00);
        cyc(1);
        chk("reacq_leds", {4'b0, leds()}, 8'b0000_1110);
        chk("reacq_coils", {4'b0, coils()}, {4'b0, pat[0]});
        cyc(5);
        chk("reacq_fast_rev", {4'b0, coils()}, {4'b0, pat[7]});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/stepper_motor_ctrl.md
Name: stepper_motor_ctrl

Overview:
Board-level controller for a unipolar stepper (28BYJ-48 via ULN2003) on a 27 MHz FPGA. Three level-sensitive buttons select run/stop, direction and speed. A prescaled step tick advances an 8-state half-step sequence driven on coil outputs in1..in4. Four status LEDs mirror the state.

Parameters:
CLK_HZ, 27_000_000, input clock frequency; documentation only, no logic depends on it.
SLOW_DIV, 54_000, clock cycles per step when btn_speed=0 (500 steps/s); must be >=2.
FAST_DIV, 27_000, clock cycles per step when btn_speed=1 (1000 steps/s); must be >=2.
DEB_CYCLES, 270_000, consecutive stable cycles a button needs before its filtered value changes (10 ms); must be >=1.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
btn_start_stop  in  1  level: 1=run, 0=stop; asynchronous to clk
btn_direction_control  in  1  level: 0=forward, 1=reverse; asynchronous
btn_speed  in  1  level: 0=slow (SLOW_DIV), 1=fast (FAST_DIV); asynchronous
in1  out  1  coil A drive, active-high
in2  out  1  coil B drive, active-high
in3  out  1  coil C drive, active-high
in4  out  1  coil D drive, active-high
led  out  1  running indicator (filtered run)
led1  out  1  direction indicator (filtered dir)
led2  out  1  speed indicator (filtered speed)
led3  out  1  step heartbeat, toggles on every step tick

Behaviour:
- One clock domain, clocked by clk. Reset is synchronous and active-high on rst. Every register is reset by rst.
- Reset values: in1..in4=0, led..led3=0, step index=0, prescaler=0, filtered buttons=0, sync flops=0.
- Input path, per button: 2-flop synchronizer, then debouncer. The filtered value takes the synchronized value only after it has differed from the filtered value for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
- Latency from a raw button edge to the filtered change: 2 + DEB_CYCLES cycles.
- Run is the filtered btn_start_stop; dir and spd are the filtered direction and speed buttons.
- Prescaler, divisor DIV = spd ? FAST_DIV : SLOW_DIV:
  - While run=0: counter held at 0 and no ticks.
  - While run=1: counter increments. When counter >= DIV-1, a tick is issued for one cycle and the counter returns to 0.
  - Using >= guarantees that switching slow->fast mid-count produces a tick on the next cycle rather than a wrap-around stall.
- Step index is 3 bits. On a tick, index = index+1 mod 8 if dir=0, or index-1 mod 8 if dir=1. 7->0 and 0->7 wrap.
- A direction change takes effect at the next tick. No extra step is inserted.
- Half-step pattern {in1,in2,in3,in4} by index:
  - 0:1000, 1:1100, 2:0100, 3:0110
  - 4:0010, 5:0011, 6:0001, 7:1001
- Coil outputs are registered:
  - run=1: outputs = pattern[index], updated the cycle after the index changes.
  - run=0: outputs = 0000 (coils de-energized). Index is retained, so a restart resumes from the same phase.
- First step after run rises: outputs show pattern[index] one cycle after run=1. The first index advance follows DIV cycles later.
- LEDs are registered: led=run, led1=dir, led2=spd. led3 toggles on each tick and holds while stopped.
- rst asserted mid-operation returns everything to reset values on the next edge, regardless of button levels. Buttons still held afterwards are re-acquired through the full synchronizer/debounce latency.
- Simultaneous button changes are filtered independently; no priority between them.

Decomposition:
- Package stepper_pkg: localparam half-step pattern table (8x4), step-index width (3), direction/speed encodings.
- Sub-module btn_debounce (parameter DEB_CYCLES; ports clk, rst, din, dout): contains synchronizer and debounce counter. Instantiated three times in stepper_motor_ctrl.

Test Plan:
(benches override SLOW_DIV=8, FAST_DIV=4, DEB_CYCLES=3)
- Reset with all buttons 0 -> outputs 0000, all LEDs 0, no activity over 100 cycles.
- Start=1, dir=0, spd=0 -> led=1 after 5 cycles. Coils read 1000, then 1100, 0100, ... 1001, 1000, advancing every 8 cycles. led3 toggles each step.
- While running, set dir=1 -> led1=1. Sequence reverses at the next tick (e.g. 0110 -> 0100 -> 1100 -> 1000 -> 1001), with wrap 0->7.
- Set spd=1 -> led2=1. Step period becomes 4 cycles. If the change arrives with the counter at 6, a tick occurs on the next cycle.
- Release start at index 5 -> coils 0000, led=0, led3 frozen. Restart resumes at pattern 0011.
- Pulse start for 2 cycles (shorter than debounce) -> no change. Assert rst mid-run -> all outputs 0 on the next edge.
